logic_arbiter: RTL and testbench
================================

Name: logic_arbiter

Overview:
- Shares one N-bit logical unit (AND/OR/XOR/NOR) between two requesters, for example the integer pipeline and a multi-cycle helper.
- Each requester presents an operand pair and an op over a valid/ready handshake.
- A round-robin arbiter picks one request per cycle. The result is registered in a single-entry output buffer and returned with the winner's ID.
- Sits beside the ALU as the only path into the shared logical unit.

Parameters:
- N, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req_valid  input  2  per-requester request valid (bit i = requester i).
- req_ready  output  2  per-requester accept; a transfer occurs when valid & ready.
- req0_A, req0_B  input  N  requester 0 operands.
- req0_op  input  2  requester 0 op: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req1_A, req1_B  input  N  requester 1 operands.
- req1_op  input  2  requester 1 op, same encoding.
- res_valid  output  1  output buffer holds a result.
- res_ready  input  1  consumer accepts the result.
- res_id  output  1  ID of the requester that owns res_R.
- res_R  output  N  registered result.
- busy  output  1  equals res_valid; status for the hazard unit.

Behaviour:
- Timing and reset:
  - One clock. Reset is asynchronous and active-low.
  - While rst_n = 0: res_valid=0, res_id=0, res_R=0, rr_ptr=0 (requester 0 has priority).
  - Deassertion of rst_n is synchronised externally.
- State machine: two states, EMPTY (res_valid=0) and FULL (res_valid=1).
  - can_accept = EMPTY | (FULL & res_ready), so a full buffer drains and refills in the same cycle.
- Grant (combinational):
  - If only one req_valid bit is set, that requester wins.
  - If both are set, requester rr_ptr wins.
  - req_ready[i] = can_accept & (winner == i). The loser's ready is 0.
  - req_ready must not depend on the same requester's req_valid.
- On an accepted request, next edge:
  - res_R = f(A, B, op) of the winner.
  - res_id = winner, res_valid = 1.
  - rr_ptr = ~winner, so the pointer moves only on an actual grant.
  - Latency: 1 cycle from accept to res_valid.
- Drain with no accept (FULL & res_ready & no req_valid): res_valid becomes 0. res_R and res_id hold their stale values.
- Stall (FULL & !res_ready): res_R and res_id stay stable and req_ready = 0.
- Requesters hold valid, A, B and op until accepted. Deasserting valid before accept is legal and drops the request.
- Throughput: one result per cycle while res_ready = 1. Under contention the requesters strictly alternate, so no starvation.
- Arithmetic: pure bitwise, width N. No flags. Every op encoding is defined, so the output is never X.
- Reset mid-operation: any held result is discarded with no completion signalled, and rr_ptr returns to 0.

Decomposition:
- Shared package: op encodings LOGIC_AND=2'b00, LOGIC_OR=2'b01, LOGIC_XOR=2'b10, LOGIC_NOR=2'b11, and the requester ID width.
- Sub-module: instantiate the existing logical unit (parameter N) once, fed by an operand/op mux driven by the winner.
- Grant logic and the output register live in logic_arbiter.

Test Plan:
- Reset: hold rst_n=0 with req_valid=2'b11 -> req_ready=00 is not required, but res_valid=0, res_R=0 and no transfer completes. On release the first grant goes to requester 0.
- Single requester: req0 A=0xF0F0_F0F0, B=0xFF00_FF00, op=00 -> next cycle res_valid=1, res_id=0, res_R=0xF000_F000. Repeat with op=11 -> res_R=0x000F_000F.
- Contention: both valid every cycle, res_ready=1; req0 op=01, req1 op=10, A=0x1234_5678, B=0x0F0F_0F0F -> results alternate res_id 0,1,0,1 with res_R 0x1F3F_5F7F (OR) and 0x1D3B_5977 (XOR).
- Back-pressure: res_ready=0 for 3 cycles while FULL -> res_R and res_id stable, req_ready=00. Raise res_ready -> same-cycle drain and refill, no bubble, no lost or duplicated result.
- Fairness after idle: grant req1, idle 5 cycles, then both valid -> requester 0 wins (pointer moved only on grant).
- Reset mid-stall: FULL with res_ready=0, pulse rst_n low -> res_valid=0 immediately (asynchronous). Held result discarded, rr_ptr=0.

Source files
------------

// File: rtl/logic_arbiter_pkg.sv
// Shared types for the logical-unit arbiter: op encodings, requester ID, buffer state.
package logic_arbiter_pkg;

  typedef enum logic [1:0] {
    LOGIC_AND = 2'b00,
    LOGIC_OR  = 2'b01,
    LOGIC_XOR = 2'b10,
    LOGIC_NOR = 2'b11
  } logic_op_e;

  localparam int unsigned ID_W = 1;
  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/logic_arbiter_if.sv
// Request/result bundle between the two requesters, the consumer and the arbiter.
interface logic_arbiter_if
  import logic_arbiter_pkg::*;
#(
  parameter int unsigned N = 32
);

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req0_A;
  logic [N-1:0] req0_B;
  logic [1:0]   req0_op;
  logic [N-1:0] req1_A;
  logic [N-1:0] req1_B;
  logic [1:0]   req1_op;
  logic         res_valid;
  logic         res_ready;
  req_id_t      res_id;
  logic [N-1:0] res_R;
  logic         busy;

  // Requesters and result consumer
  modport master (
    output req_valid, req0_A, req0_B, req0_op, req1_A, req1_B, req1_op, res_ready,
    input  req_ready, res_valid, res_id, res_R, busy
  );

  // Arbiter
  modport slave (
    input  req_valid, req0_A, req0_B, req0_op, req1_A, req1_B, req1_op, res_ready,
    output req_ready, res_valid, res_id, res_R, busy
  );

endinterface

// File: rtl/logic_arbiter_unit.sv
// Shared N-bit bitwise logical unit (AND/OR/XOR/NOR); purely combinational.
module logic_arbiter_unit
  import logic_arbiter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N-1:0] r
);

  // Every encoding is defined, so the result is never X
  always_comb begin
    r = '0;
    case (logic_op_e'(op))
      LOGIC_AND: r = a & b;
      LOGIC_OR:  r = a | b;
      LOGIC_XOR: r = a ^ b;
      LOGIC_NOR: r = ~(a | b);
      default:   r = '0;
    endcase
  end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logical unit between two requesters,
// with a single-entry registered result buffer.
module logic_arbiter
  import logic_arbiter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  logic_arbiter_if.slave  bus
);

  buf_state_e   state;
  buf_state_e   state_nxt;
  logic         rr_ptr;
  logic         can_accept;
  logic [1:0]   grant;
  logic         accept;
  req_id_t      winner;
  logic [N-1:0] mux_a;
  logic [N-1:0] mux_b;
  logic [1:0]   mux_op;
  logic [N-1:0] lu_r;

  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next state: fill on accept, drain when consumed with nothing refilling
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (bus.res_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // FSM outputs: buffer status and whether a new request may be taken
  always_comb begin
    can_accept    = 1'b0;
    bus.res_valid = 1'b0;
    case (state)
      EMPTY: can_accept = 1'b1;
      FULL: begin
        can_accept    = bus.res_ready;
        bus.res_valid = 1'b1;
      end
      default: can_accept = 1'b0;
    endcase
    bus.busy = bus.res_valid;
  end

  // Grant: each ready looks only at the other requester's valid, so a
  // requester's ready never depends on its own valid. When both are valid
  // exactly one ready is set, so grant is at most one-hot.
  always_comb begin
    bus.req_ready[0] = can_accept & (~bus.req_valid[1] | ~rr_ptr);
    bus.req_ready[1] = can_accept & (~bus.req_valid[0] |  rr_ptr);
    grant            = bus.req_valid & bus.req_ready;
    accept           = |grant;
    winner           = req_id_t'(grant[1]);
  end

  // Operand/op mux into the shared unit, steered by the winner
  always_comb begin
    if (winner == req_id_t'(1)) begin
      mux_a  = bus.req1_A;
      mux_b  = bus.req1_B;
      mux_op = bus.req1_op;
    end else begin
      mux_a  = bus.req0_A;
      mux_b  = bus.req0_B;
      mux_op = bus.req0_op;
    end
  end

  logic_arbiter_unit #(.N(N)) u_unit (
    .a  (mux_a),
    .b  (mux_b),
    .op (mux_op),
    .r  (lu_r)
  );

  // Result register and round-robin pointer; both change only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_R  <= '0;
      bus.res_id <= '0;
      rr_ptr     <= 1'b0;
    end else if (accept) begin
      bus.res_R  <= lu_r;
      bus.res_id <= winner;
      rr_ptr     <= ~winner[0];
    end
  end

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter: inputs driven and outputs sampled at the
// falling edge, away from the active rising edge.
module tb_logic_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  logic_arbiter_if #(.N(32)) bus ();

  logic_arbiter #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic v, input logic id, input logic [31:0] r);
    chk({tag, ".valid"}, 32'(bus.res_valid), 32'(v));
    chk({tag, ".busy"},  32'(bus.busy),      32'(v));
    chk({tag, ".id"},    32'(bus.res_id),    32'(id));
    chk({tag, ".R"},     bus.res_R,          r);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.req0_A  = 32'hF0F0_F0F0;
    bus.req0_B  = 32'hFF00_FF00;
    bus.req0_op = 2'b00;
    bus.req1_A  = 32'h1111_1111;
    bus.req1_B  = 32'h2222_2222;
    bus.req1_op = 2'b01;
    bus.res_ready = 1'b1;

    // Reset held with both requesting: nothing completes
    repeat (3) @(negedge clk);
    chk_res("reset", 1'b0, 1'b0, 32'h0);

    // Release: first grant to requester 0, AND
    rst_n = 1'b1;
    #1 chk("rel.ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk_res("and", 1'b1, 1'b0, 32'hF000_F000);

    // Requester 0 alone, NOR
    bus.req_valid = 2'b01;
    bus.req0_op   = 2'b11;
    #1 chk("nor.ready0", 32'(bus.req_ready[0]), 32'h1);
    @(negedge clk);
    chk_res("nor", 1'b1, 1'b0, 32'h000F_000F);

    // Requester 1 alone, XOR
    bus.req_valid = 2'b10;
    bus.req1_A  = 32'hAAAA_5555;
    bus.req1_B  = 32'h0F0F_0F0F;
    bus.req1_op = 2'b10;
    #1 chk("xor1.ready1", 32'(bus.req_ready[1]), 32'h1);
    @(negedge clk);
    chk_res("xor1", 1'b1, 1'b1, 32'hA5A5_5A5A);

    // Contention: strict alternation 0,1,0,1
    bus.req_valid = 2'b11;
    bus.req0_A  = 32'h1234_5678;
    bus.req0_B  = 32'h0F0F_0F0F;
    bus.req0_op = 2'b01;
    bus.req1_A  = 32'h1234_5678;
    bus.req1_B  = 32'h0F0F_0F0F;
    bus.req1_op = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cont.ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      @(negedge clk);
      if (i % 2 == 0) chk_res("cont.or",  1'b1, 1'b0, 32'h1F3F_5F7F);
      else            chk_res("cont.xor", 1'b1, 1'b1, 32'h1D3B_5977);
    end

    // Back-pressure: held result stable, no ready
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      chk_res("stall", 1'b1, 1'b1, 32'h1D3B_5977);
    end

    // Release: drain and refill in the same cycle
    bus.res_ready = 1'b1;
    #1 chk("refill.ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk_res("refill", 1'b1, 1'b0, 32'h1F3F_5F7F);

    // Drain with no request: valid drops, data stale
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk_res("drain", 1'b0, 1'b0, 32'h1F3F_5F7F);

    // Fairness after idle: grant req1, idle, then both -> req0 wins
    bus.req_valid = 2'b10;
    #1 chk("fair1.ready1", 32'(bus.req_ready[1]), 32'h1);
    @(negedge clk);
    chk_res("fair1", 1'b1, 1'b1, 32'h1D3B_5977);
    bus.req_valid = 2'b00;
    repeat (5) @(negedge clk);
    chk_res("idle", 1'b0, 1'b1, 32'h1D3B_5977);
    bus.req_valid = 2'b11;
    #1 chk("fair.ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk_res("fair0", 1'b1, 1'b0, 32'h1F3F_5F7F);

    // Reset mid-stall: asynchronous clear, pointer back to 0
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst.valid", 32'(bus.res_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_res("async_rst", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    #1 chk("post_rst.ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk_res("post_rst", 1'b1, 1'b0, 32'h1F3F_5F7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
